// File: rtl/serial_capture.sv
// rtl/serial_capture.sv - C/D serial line receiver: synchronise, detect C rise, shift D into words
// Completed words leave on a valid/ready handshake with sticky overrun and a frame timeout pulse.
module serial_capture #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1023,
   parameter bit MSB_FIRST   = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       ser_c,
   input  logic                       ser_d,
   output logic [WIDTH-1:0]           data,
   output logic                       valid,
   input  logic                       ready,
   output logic                       busy,
   output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
   output logic                       overrun,
   input  logic                       clr_ovr,
   output logic                       timeout
);
   localparam int CW = $clog2(WIDTH+1);
   localparam int TW = $clog2(TIMEOUT+1);
   localparam logic S_IDLE  = 1'b0;
   localparam logic S_SHIFT = 1'b1;

   logic [SYNC_STAGES-1:0] r_c_sync, r_d_sync;
   logic                   r_c_prev;
   logic                   r_state;
   logic [WIDTH-1:0]       r_sh, r_data;
   logic [CW-1:0]          r_bit_cnt;
   logic [TW-1:0]          r_idle;
   logic                   r_valid, r_overrun, r_timeout;

   logic                   w_c, w_d, w_rise, w_take, w_complete;
   logic [CW-1:0]          w_cnt_next;
   logic [WIDTH:0]         w_cat;
   logic [WIDTH-1:0]       w_sh_next;

   always_comb begin
      w_c        = r_c_sync[SYNC_STAGES-1];
      w_d        = r_d_sync[SYNC_STAGES-1];
      w_rise     = w_c & ~r_c_prev;
      w_take     = en & w_rise;
      w_cnt_next = r_bit_cnt + CW'(1);
      w_complete = w_take & (w_cnt_next == CW'(WIDTH));
      // The WIDTH+1 concatenation avoids a zero-width slice when WIDTH=1.
      if (MSB_FIRST) begin
         w_cat     = {r_sh, w_d};
         w_sh_next = w_cat[WIDTH-1:0];
      end else begin
         w_cat     = {w_d, r_sh};
         w_sh_next = w_cat[WIDTH:1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c_sync  <= '0;
         r_d_sync  <= '0;
         r_c_prev  <= 1'b0;
         r_state   <= S_IDLE;
         r_sh      <= '0;
         r_bit_cnt <= '0;
         r_idle    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_c_sync  <= {r_c_sync[SYNC_STAGES-2:0], ser_c};
         r_d_sync  <= {r_d_sync[SYNC_STAGES-2:0], ser_d};
         r_c_prev  <= w_c;
         r_timeout <= 1'b0;
         if (!en) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_idle    <= '0;
         end else if (w_rise) begin
            r_sh   <= w_sh_next;
            r_idle <= '0;
            if (w_complete) begin
               r_state   <= S_IDLE;
               r_bit_cnt <= '0;
            end else begin
               r_state   <= S_SHIFT;
               r_bit_cnt <= w_cnt_next;
            end
         end else if (r_state == S_SHIFT) begin
            if (r_idle == TW'(TIMEOUT-1)) begin
               r_timeout <= 1'b1;
               r_state   <= S_IDLE;
               r_bit_cnt <= '0;
               r_idle    <= '0;
            end else begin
               r_idle <= r_idle + TW'(1);
            end
         end
      end
   end

   // A new word may replace the held one only if the consumer takes the old one in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (clr_ovr)
            r_overrun <= 1'b0;
         if (w_complete) begin
            if (!r_valid || ready) begin
               r_data  <= w_sh_next;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data    = r_data;
   assign valid   = r_valid;
   assign busy    = (r_state == S_SHIFT);
   assign bit_cnt = r_bit_cnt;
   assign overrun = r_overrun;
   assign timeout = r_timeout;
endmodule
